// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C SCL generator: quarter-period phase
// encoding and per-quarter output decode.
package i2c_pkg;

  typedef enum logic [1:0] {
    PH_LO_D0 = 2'd0,
    PH_LO_D1 = 2'd1,
    PH_HI_D1 = 2'd2,
    PH_HI_D0 = 2'd3
  } phase_t;

  localparam int unsigned NUM_QUARTERS = 4;

  function automatic logic phase_scl_low(input phase_t ph);
    return (ph == PH_LO_D0) || (ph == PH_LO_D1);
  endfunction

  function automatic logic phase_data_clk(input phase_t ph);
    return (ph == PH_LO_D1) || (ph == PH_HI_D1);
  endfunction

endpackage

// File: rtl/i2c_sync.sv
// N-stage synchroniser for an asynchronous single-bit input, with a
// selectable reset value so an idle-high bus line resets to its idle level.
module i2c_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift chain: bit 0 samples the raw input, the top bit is the safe output.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/i2c_scl_gen.sv
// I2C master SCL generator: four-quarter period counter, open-drain SCL enable,
// slave clock-stretch freeze at the high-quarter sample point, and stretch timeout.
module i2c_scl_gen
  import i2c_pkg::*;
#(
  parameter int unsigned DIVIDER     = 250,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   scl_in,
  input  logic   clr_timeout,
  output logic   scl_oe,
  output logic   data_clk,
  output phase_t phase,
  output logic   tick,
  output logic   stretching,
  output logic   busy,
  output logic   timeout
);

  localparam int unsigned CBITS = $clog2(NUM_QUARTERS * DIVIDER);
  localparam int unsigned TBITS = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit          TO_EN = (TIMEOUT_CYC > 0);

  localparam logic [CBITS-1:0] CNT_LAST   = CBITS'(NUM_QUARTERS * DIVIDER - 1);
  localparam logic [CBITS-1:0] CNT_DIV    = CBITS'(DIVIDER);
  // Sample point sits SYNC_STAGES into the high quarter so the synchroniser
  // has flushed the level from before SCL was released.
  localparam logic [CBITS-1:0] CNT_SAMPLE = CBITS'(2 * DIVIDER + SYNC_STAGES);
  localparam logic [TBITS-1:0] STR_LIMIT  = TO_EN ? TBITS'(TIMEOUT_CYC - 1) : '0;

  logic [CBITS-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             to_q, to_d;
  logic [TBITS-1:0] scnt_q, scnt_d;

  logic             scl_s;
  logic             freeze_s;
  logic [CBITS-1:0] quot_s;
  phase_t           phase_s;

  i2c_sync #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_scl_sync (
    .clk(clk),
    .rst(rst),
    .d_i(scl_in),
    .q_o(scl_s)
  );

  assign freeze_s = run_q && (cnt_q == CNT_SAMPLE) && !scl_s;
  assign quot_s   = cnt_q / CNT_DIV;
  assign phase_s  = phase_t'(quot_s[1:0]);

  // Next-state for period counter, run flag, stretch counter and sticky timeout.
  always_comb begin
    cnt_d  = cnt_q;
    run_d  = run_q;
    scnt_d = scnt_q;
    if (clr_timeout) begin
      to_d = 1'b0;
    end else begin
      to_d = to_q;
    end

    if (!run_q) begin
      cnt_d  = '0;
      scnt_d = '0;
      if (en && !to_q) begin
        run_d = 1'b1;
      end else begin
        run_d = 1'b0;
      end
    end else if (freeze_s) begin
      if (TO_EN && (scnt_q == STR_LIMIT)) begin
        to_d   = 1'b1;
        run_d  = 1'b0;
        cnt_d  = '0;
        scnt_d = '0;
      end else begin
        scnt_d = TO_EN ? (scnt_q + TBITS'(1)) : '0;
      end
    end else begin
      scnt_d = '0;
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        run_d = en;
      end else begin
        cnt_d = cnt_q + CBITS'(1);
        run_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      to_q   <= 1'b0;
      scnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      to_q   <= to_d;
      scnt_q <= scnt_d;
    end
  end

  // The freeze point is never a quarter boundary, so tick cannot repeat while frozen.
  assign scl_oe     = run_q & phase_scl_low(phase_s);
  assign data_clk   = run_q & phase_data_clk(phase_s);
  assign phase      = phase_s;
  assign tick       = run_q & (cnt_q % CNT_DIV == '0);
  assign stretching = freeze_s;
  assign busy       = run_q;
  assign timeout    = to_q;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Randomized scoreboard bench for i2c_scl_gen: planned periods push expected
// tick/timeout events; a negedge monitor pops and compares them.
module tb_i2c_scl_gen;
  import i2c_pkg::*;

  localparam int D  = 8;
  localparam int S  = 2;
  localparam int TO = 40;
  localparam int EV_TICK = 0;
  localparam int EV_TO   = 1;

  typedef struct {
    int kind;
    int ph;
    int gap;
    int str;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst, en, clr_timeout, hold;
  logic   scl_in, scl_oe, data_clk, tick, stretching, busy, timeout;
  phase_t phase;
  logic   en0, clr0, hold0;
  logic   scl_in0, scl_oe0, data_clk0, tick0, stretching0, busy0, timeout0;
  phase_t phase0;

  exp_t exp_q[$];
  int   hold_q[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   str0_acc = 0;
  bit   slave_busy = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (stretching0) str0_acc <= str0_acc + 1;

  // Open-drain bus: low if master or slave pulls.
  assign scl_in  = ~scl_oe & ~hold;
  assign scl_in0 = ~scl_oe0 & ~hold0;

  i2c_scl_gen #(.DIVIDER(D), .SYNC_STAGES(S), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .scl_in(scl_in), .clr_timeout(clr_timeout),
    .scl_oe(scl_oe), .data_clk(data_clk), .phase(phase), .tick(tick),
    .stretching(stretching), .busy(busy), .timeout(timeout)
  );

  i2c_scl_gen #(.DIVIDER(D), .SYNC_STAGES(S), .TIMEOUT_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .en(en0), .scl_in(scl_in0), .clr_timeout(clr0),
    .scl_oe(scl_oe0), .data_clk(data_clk0), .phase(phase0), .tick(tick0),
    .stretching(stretching0), .busy(busy0), .timeout(timeout0)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL period as seen on the bus: quarters of D cycles, the high quarter
  // stretched by h cycles, or a timeout once h reaches TO.
  task automatic plan_period(input int h, input bit first);
    exp_q.push_back('{EV_TICK, 0, first ? -1 : D, 0});
    exp_q.push_back('{EV_TICK, 1, D, 0});
    exp_q.push_back('{EV_TICK, 2, D, 0});
    if (h >= TO) exp_q.push_back('{EV_TO, 0, S + TO, TO});
    else         exp_q.push_back('{EV_TICK, 3, D + h, h});
    hold_q.push_back(h);
  endtask

  task automatic wait_ph0(input int n, output bit ok);
    int seen = 0;
    for (int i = 0; i < 4000 && seen < n; i++) begin
      cyc_wait(1);
      if (tick && busy && phase == PH_LO_D0) seen++;
    end
    ok = (seen == n);
  endtask

  // Called on the cnt=0 cycle of the last planned period.
  task automatic stop_at5(input int h_last);
    int k = 0;
    cyc_wait(5);
    en = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc_wait(1);
      k++;
      if (!busy) break;
    end
    chk("stop_latency", k, 4 * D + h_last - 5);
    chk("stop_scl_oe", scl_oe, 0);
    cyc_wait(3);
    chk("idle_busy", busy, 0);
    chk("idle_phase", int'(phase), 0);
    chk("idle_tick", tick, 0);
    chk("idle_data_clk", data_clk, 0);
  endtask

  task automatic wait_slave_idle();
    for (int i = 0; i < 300 && slave_busy; i++) cyc_wait(1);
    chk("slave_released", slave_busy, 0);
  endtask

  // Slave model: starts holding SCL in the low data quarter, keeps it low h
  // cycles beyond the master's release.
  initial begin
    int h, n;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && busy && tick && phase == PH_LO_D1 && hold_q.size() > 0) begin
        h = hold_q.pop_front();
        slave_busy = 1'b1;
        hold = 1'b1;
        n = 0;
        while (scl_oe && n < 4 * D) begin
          @(negedge clk);
          n++;
        end
        repeat (h) @(negedge clk);
        hold = 1'b0;
        slave_busy = 1'b0;
      end
    end
  end

  // Monitor: pops one expected event per tick or timeout assertion.
  initial begin
    int   str_acc = 0;
    int   last_tick = 0;
    bit   prev_to = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        str_acc = 0;
        last_tick = 0;
        prev_to = 1'b0;
      end else begin
        if (stretching) str_acc++;
        if (tick) begin
          if (exp_q.size() == 0) chk("unexpected_tick", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("event_kind_tick", EV_TICK, e.kind);
            chk("tick_phase", int'(phase), e.ph);
            chk("tick_scl_oe", scl_oe, (e.ph < 2) ? 1 : 0);
            chk("tick_data_clk", data_clk, (e.ph == 1 || e.ph == 2) ? 1 : 0);
            if (e.gap >= 0) chk("tick_gap", cyc - last_tick, e.gap);
            chk("tick_stretch_cycles", str_acc, e.str);
          end
          last_tick = cyc;
          str_acc = 0;
        end
        if (timeout && !prev_to) begin
          if (exp_q.size() == 0) chk("unexpected_timeout", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("event_kind_timeout", EV_TO, e.kind);
            chk("timeout_gap", cyc - last_tick, e.gap);
            chk("timeout_stretch_cycles", str_acc, e.str);
            chk("timeout_scl_oe", scl_oe, 0);
            chk("timeout_busy", busy, 0);
            chk("timeout_stretching", stretching, 0);
          end
          str_acc = 0;
        end
        prev_to = timeout;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int hl, t0, t1;
    bit ok;
    rst = 1'b1; en = 1'b0; clr_timeout = 1'b0;
    en0 = 1'b0; clr0 = 1'b0; hold0 = 1'b0;
    cyc_wait(3);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_data_clk", data_clk, 0);
    chk("rst_phase", int'(phase), 0);
    chk("rst_tick", tick, 0);
    chk("rst_stretching", stretching, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;

    // Continuous periods: no stretch, a 10-cycle stretch, then random stretches.
    plan_period(0, 1'b1);
    plan_period(10, 1'b0);
    for (int i = 0; i < 3; i++) plan_period(int'($urandom_range(0, 39)), 1'b0);
    hl = int'($urandom_range(0, 39));
    plan_period(hl, 1'b0);
    en = 1'b1;
    wait_ph0(6, ok);
    chk("run_periods_started", ok, 1);
    stop_at5(hl);

    // Stretch beyond the limit, en ignored while timed out, clear and restart.
    cyc_wait(2);
    plan_period(60, 1'b1);
    en = 1'b1;
    for (int i = 0; i < 300 && !timeout; i++) cyc_wait(1);
    chk("timeout_set", timeout, 1);
    cyc_wait(10);
    chk("timeout_en_ignored", busy, 0);
    chk("timeout_sticky", timeout, 1);
    wait_slave_idle();
    hl = int'($urandom_range(0, 20));
    plan_period(hl, 1'b1);
    clr_timeout = 1'b1;
    cyc_wait(1);
    clr_timeout = 1'b0;
    chk("timeout_cleared", timeout, 0);
    wait_ph0(1, ok);
    chk("restart_after_clear", ok, 1);
    stop_at5(hl);

    // Reset in the middle of a stretch.
    cyc_wait(2);
    plan_period(30, 1'b1);
    en = 1'b1;
    for (int i = 0; i < 100 && !stretching; i++) cyc_wait(1);
    chk("stretch_seen", stretching, 1);
    cyc_wait(5);
    rst = 1'b1;
    en = 1'b0;
    cyc_wait(1);
    exp_q.delete();
    chk("midrst_scl_oe", scl_oe, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_stretching", stretching, 0);
    chk("midrst_tick", tick, 0);
    chk("midrst_phase", int'(phase), 0);
    chk("midrst_data_clk", data_clk, 0);
    chk("midrst_timeout", timeout, 0);
    rst = 1'b0;
    wait_slave_idle();
    hold_q.delete();

    // Timeout disabled: a 200-cycle stretch simply lengthens the period.
    t0 = 0; t1 = 0;
    en0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc_wait(1);
      if (tick0 && phase0 == PH_LO_D0) begin t0 = cyc; break; end
    end
    for (int i = 0; i < 40 && !(tick0 && phase0 == PH_LO_D1); i++) cyc_wait(1);
    hold0 = 1'b1;
    for (int i = 0; i < 40 && scl_oe0; i++) cyc_wait(1);
    cyc_wait(200);
    hold0 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      cyc_wait(1);
      if (tick0 && phase0 == PH_LO_D0) begin t1 = cyc; break; end
    end
    en0 = 1'b0;
    chk("notimeout_period", t1 - t0, 4 * D + 200);
    chk("notimeout_stretch_cycles", str0_acc, 200);
    chk("notimeout_flag", timeout0, 0);
    chk("notimeout_busy", busy0, 1);

    cyc_wait(4 * D + 4);
    chk("notimeout_stopped", busy0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
